ro_line_responder: RTL and testbench

- Memory-side responder for the read-only `mem_interface` burst protocol used by the instruction cache: `request`, `addr`, `rlen`, `ack`, `rvalid`, `rdata`.
- Accepts one line request at a time and acknowledges it with a single-cycle `ack`.
- Streams `rlen+1` words from a local single-port-read word RAM, starting at the line-aligned base.
- Provides a load port for preloading program images. Used as on-chip instruction memory and as the bench-side model for cache verification.

---
 rtl/ro_line_responder_if.sv | 26 ++
 rtl/ro_line_responder.sv | 179 +++++++++++++++++
 tb/tb_ro_line_responder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_line_responder_if.sv
// Read-only line-burst bus between an instruction-cache master and a memory
// responder.
//   request : master holds high until ack
//   addr    : word address (byte address [31:2])
//   rlen    : burst length minus one (rlen+1 is a power of two)
//   ack     : one-cycle acceptance pulse from the responder
//   rvalid  : rdata carries a beat this cycle
//   rdata   : returned word
interface ro_line_responder_if;
  logic        request;
  logic [29:0] addr;
  logic [4:0]  rlen;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output request, addr, rlen,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  request, addr, rlen,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/ro_line_responder.sv
// Memory-side responder for read-only line bursts. Accepts one line request
// at a time, acknowledges it with a single-cycle ack, then streams rlen+1
// words from a local word RAM starting at the line-aligned base address.
// A load port allows program images to be preloaded in any state.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of the line-burst bus
//   load_en   : RAM write enable
//   load_addr : RAM write word address
//   load_data : RAM write data
//   busy      : high from the ack cycle through the final beat
module ro_line_responder #(
  parameter int unsigned DEPTH_W            = 12,
  parameter int unsigned FIRST_WORD_LATENCY = 1,
  parameter int unsigned BEAT_GAP           = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  ro_line_responder_if.slave     bus,
  input  logic                   load_en,
  input  logic [DEPTH_W-1:0]     load_addr,
  input  logic [31:0]            load_data,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WAIT,
    S_BEAT,
    S_GAP
  } state_e;

  // WAIT holds for FIRST_WORD_LATENCY-1 cycles; a latency of 1 skips it.
  localparam logic [3:0] WAIT_INIT =
    (FIRST_WORD_LATENCY >= 2) ? 4'(FIRST_WORD_LATENCY - 2) : 4'd0;
  localparam logic [1:0] GAP_INIT =
    (BEAT_GAP >= 1) ? 2'(BEAT_GAP - 1) : 2'd0;

  logic [31:0]        mem [2**DEPTH_W];

  state_e             state_q;
  logic [DEPTH_W-1:0] base_q;
  logic [4:0]         len_q;
  logic [4:0]         beat_cnt_q;
  logic [3:0]         wait_cnt_q;
  logic [1:0]         gap_cnt_q;
  logic               last_q;
  logic               ack_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               busy_q;

  logic [DEPTH_W-1:0] rd_addr_d;
  logic               fire_beat_d;
  logic               unused_addr_hi;

  // Only the low DEPTH_W address bits matter; the RAM image wraps.
  assign unused_addr_hi = ^bus.addr[29:DEPTH_W];

  assign rd_addr_d = base_q + DEPTH_W'(beat_cnt_q);

  // The RAM read for a beat happens on the edge that enters BEAT, so rdata is
  // a registered RAM output valid in the same cycle rvalid goes high.
  always_comb begin
    fire_beat_d = 1'b0;
    case (state_q)
      S_ACK:   fire_beat_d = (FIRST_WORD_LATENCY == 1);
      S_WAIT:  fire_beat_d = (wait_cnt_q == '0);
      S_BEAT:  fire_beat_d = !last_q && (BEAT_GAP == 0);
      S_GAP:   fire_beat_d = (gap_cnt_q == '0);
      default: fire_beat_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      last_q     <= 1'b0;
      ack_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.request) begin
            state_q    <= S_ACK;
            base_q     <= bus.addr[DEPTH_W-1:0] & ~DEPTH_W'(bus.rlen);
            len_q      <= bus.rlen;
            beat_cnt_q <= '0;
            ack_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_ACK: begin
          state_q    <= S_WAIT;
          wait_cnt_q <= WAIT_INIT;
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        S_BEAT: begin
          rvalid_q <= 1'b0;
          if (last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_GAP;
            gap_cnt_q <= GAP_INIT;
          end
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q - 2'd1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Entering BEAT overrides the per-state transitions above.
      if (fire_beat_d) begin
        state_q    <= S_BEAT;
        rvalid_q   <= 1'b1;
        rdata_q    <= mem[rd_addr_d];
        beat_cnt_q <= beat_cnt_q + 5'd1;
        last_q     <= (beat_cnt_q == len_q);
      end
    end
  end

  assign bus.ack    = ack_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign busy       = busy_q;

  // Beat counting across bursts, consumed only by the assertion below.
  logic [5:0] chk_beats_q;
  logic [5:0] chk_expect_q;
  logic       chk_armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_beats_q  <= '0;
      chk_expect_q <= '0;
      chk_armed_q  <= 1'b0;
    end else if (state_q == S_ACK) begin
      chk_beats_q  <= '0;
      chk_expect_q <= {1'b0, len_q} + 6'd1;
      chk_armed_q  <= 1'b1;
    end else if (rvalid_q) begin
      chk_beats_q <= chk_beats_q + 6'd1;
    end
  end

  a_rvalid_busy : assert property (@(posedge clk) disable iff (rst)
    rvalid_q |-> busy_q);

  a_ack_request : assert property (@(posedge clk) disable iff (rst)
    ack_q |-> bus.request);

  a_beats_per_burst : assert property (@(posedge clk) disable iff (rst)
    (state_q == S_ACK && chk_armed_q) |-> (chk_beats_q == chk_expect_q));

  a_rlen_pow2 : assert property (@(posedge clk) disable iff (rst)
    (state_q == S_IDLE && bus.request) |-> ((bus.rlen & (bus.rlen + 5'd1)) == 5'd0));

endmodule

// File: tb/tb_ro_line_responder.sv
module tb_ro_line_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ro_line_responder_if bus_a ();
  ro_line_responder_if bus_b ();
  ro_line_responder_if bus_c ();

  logic        la_en, lb_en, lc_en;
  logic [11:0] la_addr, lb_addr;
  logic [5:0]  lc_addr;
  logic [31:0] la_data, lb_data, lc_data;
  logic        busy_a, busy_b, busy_c;

  ro_line_responder #(.DEPTH_W(12), .FIRST_WORD_LATENCY(1), .BEAT_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .load_en(la_en), .load_addr(la_addr), .load_data(la_data), .busy(busy_a));

  ro_line_responder #(.DEPTH_W(12), .FIRST_WORD_LATENCY(4), .BEAT_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .load_en(lb_en), .load_addr(lb_addr), .load_data(lb_data), .busy(busy_b));

  ro_line_responder #(.DEPTH_W(6), .FIRST_WORD_LATENCY(1), .BEAT_GAP(0)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave),
    .load_en(lc_en), .load_addr(lc_addr), .load_data(lc_data), .busy(busy_c));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];

  typedef struct {
    int   ack_k;
    int   ack2_k;
    int   first_k;
    int   last_k;
    int   beats;
    int   acks;
    int   beats_at_2nd;
    int   min_sp;
    int   max_sp;
    logic busy_after;
    bit   timeout;
  } burst_obs_t;

  // Scoreboards: every beat must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (bus_a.rvalid === 1'b1) begin
      n_checks++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_beat: got %h expected no beat", bus_a.rdata);
      end else begin
        logic [31:0] e;
        e = exp_a.pop_front();
        if (bus_a.rdata !== e) begin
          n_fail++;
          $display("FAIL a_rdata: got %h expected %h", bus_a.rdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.rvalid === 1'b1) begin
      n_checks++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_beat: got %h expected no beat", bus_b.rdata);
      end else begin
        logic [31:0] e;
        e = exp_b.pop_front();
        if (bus_b.rdata !== e) begin
          n_fail++;
          $display("FAIL b_rdata: got %h expected %h", bus_b.rdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_c.rvalid === 1'b1) begin
      n_checks++;
      if (exp_c.size() == 0) begin
        n_fail++;
        $display("FAIL c_unexpected_beat: got %h expected no beat", bus_c.rdata);
      end else begin
        logic [31:0] e;
        e = exp_c.pop_front();
        if (bus_c.rdata !== e) begin
          n_fail++;
          $display("FAIL c_rdata: got %h expected %h", bus_c.rdata, e);
        end
      end
    end
  end

  function automatic logic get_ack(input int sel);
    case (sel)
      0:       return bus_a.ack;
      1:       return bus_b.ack;
      default: return bus_c.ack;
    endcase
  endfunction

  function automatic logic get_rv(input int sel);
    case (sel)
      0:       return bus_a.rvalid;
      1:       return bus_b.rvalid;
      default: return bus_c.rvalid;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    case (sel)
      0:       return bus_a.rdata;
      1:       return bus_b.rdata;
      default: return bus_c.rdata;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic req, input logic [29:0] a, input logic [4:0] rl);
    case (sel)
      0:       begin bus_a.request = req; bus_a.addr = a; bus_a.rlen = rl; end
      1:       begin bus_b.request = req; bus_b.addr = a; bus_b.rlen = rl; end
      default: begin bus_c.request = req; bus_c.addr = a; bus_c.rlen = rl; end
    endcase
  endtask

  task automatic set_load(input int sel, input logic en, input logic [11:0] a, input logic [31:0] d);
    case (sel)
      0:       begin la_en = en; la_addr = a;     la_data = d; end
      1:       begin lb_en = en; lb_addr = a;     lb_data = d; end
      default: begin lc_en = en; lc_addr = a[5:0]; lc_data = d; end
    endcase
  endtask

  task automatic push_seq(input int sel, input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      case (sel)
        0:       exp_a.push_back(first + 32'(i));
        1:       exp_b.push_back(first + 32'(i));
        default: exp_c.push_back(first + 32'(i));
      endcase
    end
  endtask

  // Drives one request (or two, back-to-back, holding request across the
  // first burst) and records timing in cycles counted from the request.
  task automatic run_burst(input int sel, input logic [29:0] a0, input logic [29:0] a1,
                           input logic [4:0] rl, input bit b2b, input int load_k,
                           input logic [11:0] ld_addr, input logic [31:0] ld_data,
                           output burst_obs_t o);
    int want_acks;
    int want_beats;
    bit rel;
    bit done;
    logic s_ack, s_rv, s_busy;
    want_acks  = b2b ? 2 : 1;
    want_beats = want_acks * (int'(rl) + 1);
    o.ack_k = -1; o.ack2_k = -1; o.first_k = -1; o.last_k = -1;
    o.beats = 0; o.acks = 0; o.beats_at_2nd = -1;
    o.min_sp = 1000; o.max_sp = 0; o.busy_after = 1'bx; o.timeout = 1'b0;
    rel  = 1'b0;
    done = 1'b0;
    set_req(sel, 1'b1, a0, rl);
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      s_ack  = get_ack(sel);
      s_rv   = get_rv(sel);
      s_busy = get_busy(sel);
      if (rel) begin
        set_req(sel, 1'b0, a0, rl);
        rel = 1'b0;
      end
      if (k == load_k)          set_load(sel, 1'b1, ld_addr, ld_data);
      else if (k == load_k + 1) set_load(sel, 1'b0, '0, '0);
      if (s_ack === 1'b1) begin
        o.acks++;
        if (o.acks == 1) o.ack_k = k;
        else begin
          o.ack2_k       = k;
          o.beats_at_2nd = o.beats;
        end
        if (o.acks >= want_acks) rel = 1'b1;
        else                     set_req(sel, 1'b1, a1, rl);
      end
      if (s_rv === 1'b1) begin
        if (o.beats > 0) begin
          if (k - o.last_k < o.min_sp) o.min_sp = k - o.last_k;
          if (k - o.last_k > o.max_sp) o.max_sp = k - o.last_k;
        end else begin
          o.first_k = k;
        end
        o.last_k = k;
        o.beats++;
      end
      if (o.beats >= want_beats && o.acks >= want_acks && s_rv !== 1'b1 && !rel) begin
        o.busy_after = s_busy;
        done = 1'b1;
      end
    end
    if (!done) o.timeout = 1'b1;
    set_req(sel, 1'b0, a0, rl);
    set_load(sel, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (get_ack(s) !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b expected 0", s, get_ack(s)); end
      n_checks++;
      if (get_rv(s) !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", s, get_rv(s)); end
      n_checks++;
      if (get_rdata(s) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", s, get_rdata(s)); end
      n_checks++;
      if (get_busy(s) !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, get_busy(s)); end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      for (int s = 0; s < 3; s++) set_load(s, 1'b1, 12'(i), 32'h1000_0000 + 32'(i));
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) set_load(s, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_basic();
    burst_obs_t o;
    push_seq(0, 32'h1000_0010, 8);
    run_burst(0, 30'h13, 30'h0, 5'd7, 1'b0, -1, '0, '0, o);
    n_checks++;
    if (o.timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout expected completion"); end
    n_checks++;
    if (o.ack_k != 1) begin n_fail++; $display("FAIL basic_ack_latency: got %0d expected 1", o.ack_k); end
    n_checks++;
    if (o.first_k != 2) begin n_fail++; $display("FAIL basic_first_beat: got %0d expected 2", o.first_k); end
    n_checks++;
    if (o.beats != 8 || o.last_k != 9) begin n_fail++; $display("FAIL basic_beats: got %0d beats last %0d expected 8 last 9", o.beats, o.last_k); end
    n_checks++;
    if (o.min_sp != 1 || o.max_sp != 1) begin n_fail++; $display("FAIL basic_spacing: got %0d..%0d expected 1..1", o.min_sp, o.max_sp); end
    n_checks++;
    if (o.busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", o.busy_after); end
    n_checks++;
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL basic_leftover: got %0d expected 0", exp_a.size()); end
  endtask

  task automatic test_latency_gap();
    burst_obs_t o;
    push_seq(1, 32'h1000_0020, 4);
    run_burst(1, 30'h20, 30'h0, 5'd3, 1'b0, -1, '0, '0, o);
    n_checks++;
    if (o.timeout) begin n_fail++; $display("FAIL gap_timeout: got timeout expected completion"); end
    n_checks++;
    if (o.first_k - o.ack_k != 4) begin n_fail++; $display("FAIL gap_first_latency: got %0d expected 4", o.first_k - o.ack_k); end
    n_checks++;
    if (o.min_sp != 3 || o.max_sp != 3) begin n_fail++; $display("FAIL gap_spacing: got %0d..%0d expected 3..3", o.min_sp, o.max_sp); end
    n_checks++;
    if (o.beats != 4) begin n_fail++; $display("FAIL gap_beats: got %0d expected 4", o.beats); end
    n_checks++;
    if (o.busy_after !== 1'b0) begin n_fail++; $display("FAIL gap_busy_after: got %b expected 0", o.busy_after); end
    n_checks++;
    if (exp_b.size() != 0) begin n_fail++; $display("FAIL gap_leftover: got %0d expected 0", exp_b.size()); end
  endtask

  task automatic test_back_to_back();
    burst_obs_t o;
    push_seq(0, 32'h1000_0000, 16);
    run_burst(0, 30'h0, 30'h8, 5'd7, 1'b1, -1, '0, '0, o);
    n_checks++;
    if (o.acks != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d expected 2", o.acks); end
    n_checks++;
    if (o.beats_at_2nd != 8) begin n_fail++; $display("FAIL b2b_beats_before_2nd_ack: got %0d expected 8", o.beats_at_2nd); end
    n_checks++;
    if (o.ack2_k != 11) begin n_fail++; $display("FAIL b2b_2nd_ack_cycle: got %0d expected 11", o.ack2_k); end
    n_checks++;
    if (o.beats != 16) begin n_fail++; $display("FAIL b2b_total_beats: got %0d expected 16", o.beats); end
    n_checks++;
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d expected 0", exp_a.size()); end
  endtask

  task automatic test_wrap();
    burst_obs_t o;
    push_seq(2, 32'h1000_0038, 8);
    run_burst(2, 30'h7C, 30'h0, 5'd7, 1'b0, -1, '0, '0, o);
    n_checks++;
    if (o.beats != 8 || o.timeout) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 8", o.beats); end
    n_checks++;
    if (exp_c.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d expected 0", exp_c.size()); end
  endtask

  task automatic test_reset_mid_burst();
    burst_obs_t o;
    int beats;
    int stray;
    bit rel;
    push_seq(0, 32'h1000_0028, 8);
    set_req(0, 1'b1, 30'h28, 5'd7);
    beats = 0;
    rel   = 1'b0;
    for (int k = 1; k <= 40 && beats < 3; k++) begin
      @(negedge clk);
      if (rel) begin set_req(0, 1'b0, 30'h28, 5'd7); rel = 1'b0; end
      if (bus_a.ack === 1'b1) rel = 1'b1;
      if (bus_a.rvalid === 1'b1) beats++;
    end
    rst = 1'b1;
    n_checks++;
    if (beats != 3) begin n_fail++; $display("FAIL rst_pre_beats: got %0d expected 3", beats); end
    @(posedge clk);
    #1;
    exp_a.delete();
    rst = 1'b0;
    set_req(0, 1'b0, 30'h0, 5'd0);
    @(negedge clk);
    n_checks++;
    if (bus_a.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", bus_a.rvalid); end
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    n_checks++;
    if (bus_a.ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", bus_a.ack); end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.rvalid === 1'b1) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL rst_stray_beats: got %0d expected 0", stray); end
    push_seq(0, 32'h1000_0030, 4);
    run_burst(0, 30'h31, 30'h0, 5'd3, 1'b0, -1, '0, '0, o);
    n_checks++;
    if (o.acks != 1 || o.beats != 4) begin n_fail++; $display("FAIL rst_recover: got %0d acks %0d beats expected 1 acks 4 beats", o.acks, o.beats); end
    n_checks++;
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL rst_recover_leftover: got %0d expected 0", exp_a.size()); end
  endtask

  task automatic test_load_during_burst();
    burst_obs_t o;
    // Write lands two edges before beat 5's RAM read: new data is returned.
    push_seq(0, 32'h1000_0018, 5);
    exp_a.push_back(32'hDEAD_BEEF);
    push_seq(0, 32'h1000_001E, 2);
    run_burst(0, 30'h18, 30'h0, 5'd7, 1'b0, 4, 12'h1D, 32'hDEAD_BEEF, o);
    n_checks++;
    if (o.beats != 8) begin n_fail++; $display("FAIL load_early_beats: got %0d expected 8", o.beats); end
    repeat (2) @(negedge clk);
    // Write on the same edge as beat 5's RAM read: old data is returned.
    push_seq(0, 32'h1000_0028, 8);
    run_burst(0, 30'h28, 30'h0, 5'd7, 1'b0, 6, 12'h2D, 32'hCAFE_F00D, o);
    n_checks++;
    if (o.beats != 8) begin n_fail++; $display("FAIL load_same_beats: got %0d expected 8", o.beats); end
    repeat (2) @(negedge clk);
    push_seq(0, 32'h1000_0028, 5);
    exp_a.push_back(32'hCAFE_F00D);
    push_seq(0, 32'h1000_002E, 2);
    run_burst(0, 30'h28, 30'h0, 5'd7, 1'b0, -1, '0, '0, o);
    n_checks++;
    if (exp_a.size() != 0) begin n_fail++; $display("FAIL load_leftover: got %0d expected 0", exp_a.size()); end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      set_req(s, 1'b0, '0, '0);
      set_load(s, 1'b0, '0, '0);
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    preload();
    test_basic();
    repeat (3) @(negedge clk);
    test_latency_gap();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_wrap();
    repeat (3) @(negedge clk);
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    test_load_during_burst();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
